// File: rtl/div_unit_if.sv
// Handshake and result bus between the E-stage control and the multi-cycle divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic                 start;
  logic                 signedDiv;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cancel;
  logic                 stall;
  logic                 ready;
  logic [2*WIDTH-1:0]   hilo;

  modport master (
    output start, signedDiv, a, b, cancel,
    input  stall, ready, hilo
  );

  modport slave (
    input  start, signedDiv, a, b, cancel,
    output stall, ready, hilo
  );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for the E stage: {HI,LO} = {remainder, quotient},
// one quotient bit per cycle, single-cycle result for divide-by-zero.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT              state;
  stateT              nextState;

  logic [WIDTH-1:0]   remReg;
  logic [WIDTH-1:0]   dvdReg;
  logic [WIDTH-1:0]   dsrReg;
  logic [CNT_W-1:0]   cnt;
  logic               qSign;
  logic               rSign;
  logic [2*WIDTH-1:0] hiloReg;

  logic               accept;
  logic               lastIter;
  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               qBit;
  logic [WIDTH-1:0]   newRem;
  logic [WIDTH-1:0]   newDvd;
  logic [WIDTH-1:0]   quotFinal;
  logic [WIDTH-1:0]   remFinal;
  logic               stallSig;
  logic               readySig;

  assign accept   = (state == IDLE) && bus.start && !bus.cancel;
  assign lastIter = (cnt == CNT_W'(WIDTH - 1));

  // Operand magnitudes; negative values only exist for signed division.
  assign aNeg = bus.signedDiv & bus.a[WIDTH-1];
  assign bNeg = bus.signedDiv & bus.b[WIDTH-1];
  assign absA = aNeg ? (WIDTH'(0) - bus.a) : bus.a;
  assign absB = bNeg ? (WIDTH'(0) - bus.b) : bus.b;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep if non-negative.
  assign shifted   = {remReg, dvdReg[WIDTH-1]};
  assign trial     = shifted - {1'b0, dsrReg};
  assign qBit      = ~trial[WIDTH];
  assign newRem    = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign newDvd    = {dvdReg[WIDTH-2:0], qBit};
  assign quotFinal = qSign ? (WIDTH'(0) - newDvd) : newDvd;
  assign remFinal  = rSign ? (WIDTH'(0) - newRem) : newRem;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state, stall and ready decode.
  always_comb begin
    nextState = state;
    stallSig  = 1'b0;
    readySig  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stallSig  = 1'b1;
          nextState = (bus.b == '0) ? DONE : DIV;
        end
      end
      DIV: begin
        stallSig = 1'b1;
        if (bus.cancel)    nextState = IDLE;
        else if (lastIter) nextState = DONE;
      end
      DONE: begin
        readySig  = ~bus.cancel;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      remReg  <= '0;
      dvdReg  <= '0;
      dsrReg  <= '0;
      cnt     <= '0;
      qSign   <= 1'b0;
      rSign   <= 1'b0;
      hiloReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvdReg <= absA;
            dsrReg <= absB;
            remReg <= '0;
            cnt    <= '0;
            qSign  <= aNeg ^ bNeg;
            rSign  <= aNeg;
            if (bus.b == '0) hiloReg <= {bus.a, {WIDTH{1'b1}}};
          end
        end
        DIV: begin
          if (!bus.cancel) begin
            remReg <= newRem;
            dvdReg <= newDvd;
            cnt    <= cnt + CNT_W'(1);
            if (lastIter) hiloReg <= {remFinal, quotFinal};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall = stallSig;
  assign bus.ready = readySig;
  assign bus.hilo  = hiloReg;

endmodule
